// File: rtl/key_conditioner.sv
// key_conditioner: multi-channel push-button / switch conditioner.
// Each channel runs a 2-flop synchroniser, a counter debouncer, a
// level/edge output selector and an optional hold-to-repeat timer.
module key_conditioner #(
   parameter int unsigned CH_NUM     = 4,
   parameter int unsigned DEB_MAX    = 1000000,
   parameter int unsigned DEB_CNT_W  = 20,
   parameter int unsigned REP_DELAY  = 25000000,
   parameter int unsigned REP_PERIOD = 5000000,
   parameter int unsigned REP_CNT_W  = 25,
   parameter logic        IDLE_LEVEL = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CH_NUM-1:0]   trigger,
   input  logic [2*CH_NUM-1:0] mode,
   input  logic [CH_NUM-1:0]   repeat_en,
   output logic [CH_NUM-1:0]   stable,
   output logic [CH_NUM-1:0]   out
);

   typedef enum logic [1:0] {
      MODE_LEVEL = 2'b00,
      MODE_RISE  = 2'b01,
      MODE_FALL  = 2'b10,
      MODE_BOTH  = 2'b11
   } mode_e;

   localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_MAX - 1);
   localparam logic [REP_CNT_W-1:0] DLY_LAST = REP_CNT_W'(REP_DELAY - 1);
   localparam logic [REP_CNT_W-1:0] PER_LAST = REP_CNT_W'(REP_PERIOD - 1);

   if (DEB_MAX < 1) begin : g_bad_deb_max
      $error("key_conditioner: DEB_MAX must be >= 1");
   end
   if (REP_DELAY < 2) begin : g_bad_rep_delay
      $error("key_conditioner: REP_DELAY must be >= 2");
   end
   if (REP_PERIOD < 1) begin : g_bad_rep_period
      $error("key_conditioner: REP_PERIOD must be >= 1");
   end
   if ((DEB_MAX >> DEB_CNT_W) != 0) begin : g_bad_deb_w
      $error("key_conditioner: DEB_CNT_W too narrow for DEB_MAX");
   end
   if (((REP_DELAY - 1) >> REP_CNT_W) != 0 || ((REP_PERIOD - 1) >> REP_CNT_W) != 0) begin : g_bad_rep_w
      $error("key_conditioner: REP_CNT_W too narrow for repeat timing");
   end

   for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      logic                 s1;
      logic                 s2;
      logic                 stb;
      logic                 out_r;
      logic [DEB_CNT_W-1:0] deb_cnt;
      logic [REP_CNT_W-1:0] rep_cnt;
      logic                 rep_phase;
      mode_e                md;
      mode_e                mode_q;
      logic                 accept;
      logic                 stb_nxt;
      logic                 rose;
      logic                 fell;
      logic                 act_lvl;
      logic                 rep_clr;
      logic                 rep_run;
      logic                 rep_hit;
      logic                 rep_pulse;

      assign md      = mode_e'(mode[2*i +: 2]);
      assign accept  = (s2 != stb) && (deb_cnt == DEB_LAST);
      assign stb_nxt = accept ? s2 : stb;
      assign rose    = accept & s2;
      assign fell    = accept & ~s2;

      // Repeat runs only while the post-edge level is the active one and the
      // channel configuration is unchanged since the previous cycle; the press
      // edge itself restarts the timer so it can never coincide with a repeat.
      assign act_lvl   = (md == MODE_RISE);
      assign rep_clr   = !repeat_en[i] || !(md == MODE_RISE || md == MODE_FALL) || (md != mode_q);
      assign rep_run   = !rep_clr && (stb_nxt == act_lvl) && !accept;
      assign rep_hit   = rep_phase ? (rep_cnt == PER_LAST) : (rep_cnt == DLY_LAST);
      assign rep_pulse = rep_run & rep_hit;

      assign stable[i] = stb;
      assign out[i]    = out_r;

      // Two-stage synchroniser for the asynchronous pin.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            s1 <= IDLE_LEVEL;
            s2 <= IDLE_LEVEL;
         end else begin
            s1 <= trigger[i];
            s2 <= s1;
         end
      end

      // Debouncer: accept a new level after DEB_MAX consecutive differing samples.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            stb     <= IDLE_LEVEL;
            deb_cnt <= '0;
         end else begin
            stb <= stb_nxt;
            if (s2 == stb || accept) begin
               deb_cnt <= '0;
            end else begin
               deb_cnt <= deb_cnt + DEB_CNT_W'(1);
            end
         end
      end

      // Hold-to-repeat timer: initial delay phase, then periodic phase.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            rep_cnt   <= '0;
            rep_phase <= 1'b0;
            mode_q    <= MODE_LEVEL;
         end else begin
            mode_q <= md;
            if (!rep_run) begin
               rep_cnt   <= '0;
               rep_phase <= 1'b0;
            end else if (rep_hit) begin
               rep_cnt   <= '0;
               rep_phase <= 1'b1;
            end else begin
               rep_cnt <= rep_cnt + REP_CNT_W'(1);
            end
         end
      end

      // Registered output selected by the channel mode.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            out_r <= 1'b0;
         end else begin
            unique case (md)
               MODE_LEVEL: out_r <= stb;
               MODE_RISE:  out_r <= rose | rep_pulse;
               MODE_FALL:  out_r <= fell | rep_pulse;
               MODE_BOTH:  out_r <= rose | fell;
               default:    out_r <= 1'b0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed stimulus with a behavioural reference model
// checked every cycle, plus hand-computed spot checks.
module tb_key_conditioner;

   localparam int CH         = 2;
   localparam int DEB_MAX    = 4;
   localparam int REP_DELAY  = 10;
   localparam int REP_PERIOD = 3;

   logic            clk       = 1'b0;
   logic            rst_n     = 1'b1;
   logic [CH-1:0]   trigger   = '1;
   logic [2*CH-1:0] mode      = 4'b1010;
   logic [CH-1:0]   repeat_en = '0;
   logic [CH-1:0]   stable;
   logic [CH-1:0]   out;

   int passed = 0;
   int total  = 0;
   int pcount = 0;

   key_conditioner #(
      .CH_NUM    (CH),
      .DEB_MAX   (DEB_MAX),
      .DEB_CNT_W (3),
      .REP_DELAY (REP_DELAY),
      .REP_PERIOD(REP_PERIOD),
      .REP_CNT_W (4),
      .IDLE_LEVEL(1'b1)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .trigger  (trigger),
      .mode     (mode),
      .repeat_en(repeat_en),
      .stable   (stable),
      .out      (out)
   );

   always #5 clk = ~clk;

   // Reference model: sample history window, time-held counter, mode rules.
   logic [DEB_MAX+1:0] hist [CH];
   logic [CH-1:0]      m_stable = '1;
   logic [CH-1:0]      m_out    = '0;
   int                 held [CH];
   logic [1:0]         mprev [CH];

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         hist[c]  = '1;
         held[c]  = 0;
         mprev[c] = 2'b00;
      end
      m_stable = '1;
      m_out    = '0;
   endtask

   task automatic model_step(input int c);
      logic [1:0] md;
      logic old, nw, acc, rose, fell, rp, ok, act;
      hist[c] = {hist[c][DEB_MAX:0], trigger[c]};
      md   = mode[2*c +: 2];
      old  = m_stable[c];
      // New level accepted once DEB_MAX synchronised samples all differ from it.
      acc  = (hist[c][DEB_MAX+1:2] == {DEB_MAX{~old}});
      nw   = acc ? ~old : old;
      rose = acc & nw;
      fell = acc & ~nw;
      ok   = repeat_en[c] && (md == 2'b01 || md == 2'b10) && (md == mprev[c]);
      act  = (md == 2'b01);
      rp   = 1'b0;
      if (ok && nw == act && !acc) begin
         held[c]++;
         rp = (held[c] >= REP_DELAY) && (((held[c] - REP_DELAY) % REP_PERIOD) == 0);
      end else begin
         held[c] = 0;
      end
      case (md)
         2'b00:   m_out[c] = old;
         2'b01:   m_out[c] = rose | rp;
         2'b10:   m_out[c] = fell | rp;
         default: m_out[c] = rose | fell;
      endcase
      m_stable[c] = nw;
      mprev[c]    = md;
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            model_reset();
         end else begin
            for (int c = 0; c < CH; c++) model_step(c);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Compare DUT against the model on every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         check("model_stable", 32'(stable), 32'(m_stable));
         check("model_out", 32'(out), 32'(m_out));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic count(input int n);
      repeat (n) begin
         @(negedge clk);
         if (out[0]) pcount++;
      end
   endtask

   task automatic do_reset(input string tag);
      #2 rst_n = 1'b0;
      #1;
      check({tag, "_stable"}, 32'(stable), 32'h3);
      check({tag, "_out"}, 32'(out), 32'h0);
      @(negedge clk);
      #2 rst_n = 1'b1;
   endtask

   logic [30:0] rep_mask;

   initial begin
      // 1: reset
      #1 rst_n = 1'b0;
      #2;
      check("rst_stable", 32'(stable), 32'h3);
      check("rst_out", 32'(out), 32'h0);
      tick(2);
      #2 rst_n = 1'b1;
      tick(20);
      check("idle_out", 32'(out), 32'h0);

      // 2: clean press, mode 10
      trigger[0] = 1'b0;
      tick(5);
      check("press_pre_stable", 32'(stable), 32'h3);
      check("press_pre_out", 32'(out), 32'h0);
      tick(1);
      check("press_stable", 32'(stable), 32'h2);
      check("press_out", 32'(out), 32'h1);
      tick(1);
      check("press_after_out", 32'(out), 32'h0);
      trigger[0] = 1'b1;
      tick(6);
      check("release_stable", 32'(stable), 32'h3);
      check("release_out", 32'(out), 32'h0);

      // 3: bounce rejection then a clean hold
      pcount = 0;
      trigger[0] = 1'b0; count(3);
      trigger[0] = 1'b1; count(2);
      trigger[0] = 1'b0; count(3);
      trigger[0] = 1'b1; count(8);
      check("bounce_pulses", 32'(pcount), 32'd0);
      check("bounce_stable", 32'(stable), 32'h3);
      pcount = 0;
      trigger[0] = 1'b0; count(6);
      check("hold_pulses", 32'(pcount), 32'd1);
      check("hold_stable", 32'(stable), 32'h2);
      trigger[0] = 1'b1; count(8);
      check("hold_release_pulses", 32'(pcount), 32'd1);

      // 4: auto-repeat on ch0
      repeat_en = 2'b01;
      trigger[0] = 1'b0;
      tick(6);
      check("rep_first", 32'(out[0]), 32'd1);
      rep_mask = '0;
      rep_mask[10] = 1'b1; rep_mask[13] = 1'b1; rep_mask[16] = 1'b1; rep_mask[19] = 1'b1;
      rep_mask[22] = 1'b1; rep_mask[25] = 1'b1; rep_mask[28] = 1'b1;
      for (int k = 1; k <= 30; k++) begin
         tick(1);
         check("rep_train", 32'(out[0]), 32'(rep_mask[k]));
      end
      trigger[0] = 1'b1;
      tick(6);
      check("rep_release_stable", 32'(stable), 32'h3);
      check("rep_release_out", 32'(out), 32'h0);

      // mode change and repeat_en deassertion during a hold
      trigger[0] = 1'b0;
      tick(12);
      mode[1:0] = 2'b01;
      tick(8);
      mode[1:0] = 2'b10;
      tick(12);
      repeat_en = 2'b00;
      tick(5);
      trigger[0] = 1'b1;
      tick(8);

      // 5a: mode 11 with repeat_en set
      mode = 4'b1011;
      repeat_en = 2'b11;
      trigger[0] = 1'b0;
      tick(6);
      check("both_press_out", 32'(out), 32'h1);
      pcount = 0;
      count(15);
      check("both_no_repeat", 32'(pcount), 32'd0);
      trigger[0] = 1'b1;
      tick(6);
      check("both_release_out", 32'(out), 32'h1);
      check("both_release_stable", 32'(stable), 32'h3);

      // 5b: mode 00 level output, one cycle behind stable
      mode = 4'b1000;
      repeat_en = 2'b00;
      tick(2);
      do_reset("lvl_rst");
      tick(1);
      check("lvl_first", 32'(out), 32'h1);
      trigger[0] = 1'b0;
      tick(6);
      check("lvl_fall_stable", 32'(stable), 32'h2);
      check("lvl_fall_lag", 32'(out), 32'h1);
      tick(1);
      check("lvl_fall_out", 32'(out), 32'h0);
      trigger[0] = 1'b1;
      tick(6);
      check("lvl_rise_lag", 32'(out), 32'h0);
      tick(1);
      check("lvl_rise_out", 32'(out), 32'h1);

      // 5c: simultaneous presses on both channels
      mode = 4'b1010;
      tick(1);
      trigger = 2'b00;
      tick(6);
      check("dual_out", 32'(out), 32'h3);
      check("dual_stable", 32'(stable), 32'h0);
      tick(1);
      check("dual_after", 32'(out), 32'h0);
      trigger = 2'b11;
      tick(8);

      // 6: reset during debounce and during repeat phase
      repeat_en = 2'b01;
      trigger[0] = 1'b0;
      tick(4);
      do_reset("mid_deb");
      tick(5);
      check("mid_deb_pre", 32'(stable), 32'h3);
      tick(1);
      check("mid_deb_stable", 32'(stable), 32'h2);
      check("mid_deb_out", 32'(out), 32'h1);
      tick(12);
      do_reset("mid_rep");
      tick(6);
      check("mid_rep_press_out", 32'(out), 32'h1);
      check("mid_rep_press_stable", 32'(stable), 32'h2);
      for (int k = 1; k <= 10; k++) begin
         tick(1);
         check("mid_rep_train", 32'(out[0]), 32'(k == 10));
      end
      trigger[0] = 1'b1;
      tick(8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
